// File: rtl/memory_loader.sv
// Serial command front end for the processor's external memory port: parses
// W/R/P/G byte frames from a UART receiver and answers through a UART transmitter.
module memory_loader #(
    parameter logic [2:0] MODE_NONE      = 3'd0,
    parameter logic [2:0] MODE_WORD      = 3'd3,
    parameter int         READ_LATENCY   = 1,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        pause,
    output logic        externalMemoryControl,
    output logic [31:0] externalAddress,
    output logic [31:0] externalData,
    output logic [2:0]  externalReadMode,
    output logic [2:0]  externalWriteMode,
    input  logic [31:0] externalDataOut,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_DATA      = 3'd2,
        S_ACCESS    = 3'd3,
        S_READ_WAIT = 3'd4,
        S_TX        = 3'd5
    } state_t;

    localparam logic [7:0]  CMD_W        = 8'h57;
    localparam logic [7:0]  CMD_R        = 8'h52;
    localparam logic [7:0]  CMD_P        = 8'h50;
    localparam logic [7:0]  CMD_G        = 8'h47;
    localparam logic [7:0]  RSP_K        = 8'h4B;
    localparam logic [7:0]  RSP_E        = 8'h45;
    localparam logic [7:0]  RSP_Q        = 8'h3F;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  LAT_LAST     = 3'(READ_LATENCY - 1);

    state_t      state_r, nextState_s;
    logic        isWrite_r, isWrite_s;
    logic [1:0]  byteCnt_r, byteCnt_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] data_r, data_s;
    logic [31:0] timer_r, timer_s;
    logic [31:0] txBuf_r, txBuf_s;
    logic [2:0]  txLeft_r, txLeft_s;
    logic [2:0]  latCnt_r, latCnt_s;
    logic        pause_r, pause_s;
    logic        overrun_r, overrun_s;
    logic        ctrl_r, ctrl_s;
    logic        txValid_r, txValid_s;
    logic [2:0]  readMode_r, readMode_s;
    logic [2:0]  writeMode_r, writeMode_s;

    // Next-state and next-register computation for the frame parser.
    always_comb begin
        nextState_s = state_r;
        isWrite_s   = isWrite_r;
        byteCnt_s   = byteCnt_r;
        addr_s      = addr_r;
        data_s      = data_r;
        timer_s     = timer_r;
        txBuf_s     = txBuf_r;
        txLeft_s    = txLeft_r;
        latCnt_s    = latCnt_r;
        pause_s     = pause_r;
        overrun_s   = overrun_r;
        case (state_r)
            S_IDLE: begin
                timer_s   = 32'd0;
                byteCnt_s = 2'd0;
                if (rxValid) begin
                    case (rxData)
                        CMD_W: begin
                            isWrite_s   = 1'b1;
                            nextState_s = S_ADDR;
                        end
                        CMD_R: begin
                            isWrite_s   = 1'b0;
                            nextState_s = S_ADDR;
                        end
                        CMD_P: begin
                            pause_s     = 1'b1;
                            txBuf_s     = {RSP_K, 24'h000000};
                            txLeft_s    = 3'd1;
                            nextState_s = S_TX;
                        end
                        CMD_G: begin
                            pause_s     = 1'b0;
                            txBuf_s     = {RSP_K, 24'h000000};
                            txLeft_s    = 3'd1;
                            nextState_s = S_TX;
                        end
                        default: begin
                            txBuf_s     = {RSP_Q, 24'h000000};
                            txLeft_s    = 3'd1;
                            nextState_s = S_TX;
                        end
                    endcase
                end else begin
                    nextState_s = S_IDLE;
                end
            end
            S_ADDR, S_DATA: begin
                if (rxValid) begin
                    timer_s   = 32'd0;
                    byteCnt_s = byteCnt_r + 2'd1;
                    if (state_r == S_ADDR) begin
                        addr_s = {addr_r[23:0], rxData};
                    end else begin
                        data_s = {data_r[23:0], rxData};
                    end
                    if (byteCnt_r == 2'd3) begin
                        if ((state_r == S_ADDR) && isWrite_r) begin
                            nextState_s = S_DATA;
                        end else begin
                            nextState_s = S_ACCESS;
                        end
                    end else begin
                        nextState_s = state_r;
                    end
                end else if (timer_r == TIMEOUT_LAST) begin
                    // Stalled frame: drop it silently, pause state untouched.
                    nextState_s = S_IDLE;
                end else begin
                    timer_s = timer_r + 32'd1;
                end
            end
            S_ACCESS: begin
                latCnt_s = 3'd0;
                if (!pause_r) begin
                    txBuf_s     = {RSP_E, 24'h000000};
                    txLeft_s    = 3'd1;
                    nextState_s = S_TX;
                end else if (isWrite_r) begin
                    txBuf_s     = {RSP_K, 24'h000000};
                    txLeft_s    = 3'd1;
                    nextState_s = S_TX;
                end else begin
                    nextState_s = S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (latCnt_r == LAT_LAST) begin
                    txBuf_s     = externalDataOut;
                    txLeft_s    = 3'd4;
                    nextState_s = S_TX;
                end else begin
                    latCnt_s = latCnt_r + 3'd1;
                end
            end
            S_TX: begin
                if (txReady) begin
                    if (txLeft_r == 3'd1) begin
                        txLeft_s    = 3'd0;
                        nextState_s = S_IDLE;
                    end else begin
                        txBuf_s  = {txBuf_r[23:0], 8'h00};
                        txLeft_s = txLeft_r - 3'd1;
                    end
                end else begin
                    nextState_s = S_TX;
                end
            end
            default: begin
                nextState_s = S_IDLE;
            end
        endcase

        if (rxValid && ((state_r == S_ACCESS) || (state_r == S_READ_WAIT) || (state_r == S_TX))) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_s;
        end
    end

    // Memory-port and transmit strobes are decoded from the next state so they register cleanly.
    always_comb begin
        ctrl_s      = ((nextState_s == S_ACCESS) && isWrite_s && pause_s) || (nextState_s == S_READ_WAIT);
        writeMode_s = ((nextState_s == S_ACCESS) && isWrite_s && pause_s) ? MODE_WORD : MODE_NONE;
        readMode_s  = (nextState_s == S_READ_WAIT) ? MODE_WORD : MODE_NONE;
        txValid_s   = (nextState_s == S_TX);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= S_IDLE;
            isWrite_r   <= 1'b0;
            byteCnt_r   <= 2'd0;
            addr_r      <= 32'd0;
            data_r      <= 32'd0;
            timer_r     <= 32'd0;
            txBuf_r     <= 32'd0;
            txLeft_r    <= 3'd0;
            latCnt_r    <= 3'd0;
            pause_r     <= 1'b0;
            overrun_r   <= 1'b0;
            ctrl_r      <= 1'b0;
            txValid_r   <= 1'b0;
            readMode_r  <= MODE_NONE;
            writeMode_r <= MODE_NONE;
        end else begin
            state_r     <= nextState_s;
            isWrite_r   <= isWrite_s;
            byteCnt_r   <= byteCnt_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
            timer_r     <= timer_s;
            txBuf_r     <= txBuf_s;
            txLeft_r    <= txLeft_s;
            latCnt_r    <= latCnt_s;
            pause_r     <= pause_s;
            overrun_r   <= overrun_s;
            ctrl_r      <= ctrl_s;
            txValid_r   <= txValid_s;
            readMode_r  <= readMode_s;
            writeMode_r <= writeMode_s;
        end
    end

    assign txData                = txBuf_r[31:24];
    assign txValid               = txValid_r;
    assign pause                 = pause_r;
    assign overrun               = overrun_r;
    assign externalMemoryControl = ctrl_r;
    assign externalAddress       = addr_r;
    assign externalData          = data_r;
    assign externalReadMode      = readMode_r;
    assign externalWriteMode     = writeMode_r;

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader: table of command frames plus hand-written
// stall, timeout, overrun and reset sequences; tx bytes checked through a scoreboard queue.
module tb_memory_loader;

    localparam int LAT = 1;
    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic        rxValid = 1'b0;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady = 1'b1;
    logic        pause;
    logic        externalMemoryControl;
    logic [31:0] externalAddress;
    logic [31:0] externalData;
    logic [2:0]  externalReadMode;
    logic [2:0]  externalWriteMode;
    logic [31:0] externalDataOut;
    logic        overrun;

    memory_loader #(.READ_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rxData(rxData), .rxValid(rxValid),
        .txData(txData), .txValid(txValid), .txReady(txReady), .pause(pause),
        .externalMemoryControl(externalMemoryControl), .externalAddress(externalAddress),
        .externalData(externalData), .externalReadMode(externalReadMode),
        .externalWriteMode(externalWriteMode), .externalDataOut(externalDataOut),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  expQ [$];
    logic [31:0] mem [16];
    int          writes = 0;
    int          readCycles = 0;
    int          stray = 0;
    logic [31:0] lastWAddr = 32'h0;
    logic [31:0] lastWData = 32'h0;

    // Memory model: read data only visible while this block owns the port in read mode.
    always_comb begin
        if (externalMemoryControl && (externalReadMode == 3'd3)) begin
            externalDataOut = mem[externalAddress[5:2]];
        end else begin
            externalDataOut = 32'h0;
        end
    end

    // Monitor on the falling edge: tx scoreboard and memory-port activity.
    always @(negedge clk) begin
        if (rst && txValid && txReady) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("FAIL tx_unexpected: got %02h, none expected", txData);
            end else begin
                logic [7:0] e;
                e = expQ.pop_front();
                if (txData !== e) begin
                    mismatched++;
                    $display("FAIL tx_byte: got %02h, expected %02h", txData, e);
                end
            end
        end
        if (rst && externalMemoryControl) begin
            if (externalWriteMode == 3'd3 && externalReadMode == 3'd0) begin
                writes++;
                lastWAddr = externalAddress;
                lastWData = externalData;
                mem[externalAddress[5:2]] = externalData;
            end else if (externalReadMode == 3'd3 && externalWriteMode == 3'd0) begin
                readCycles++;
            end else begin
                stray++;
            end
        end else if (externalReadMode != 3'd0 || externalWriteMode != 3'd0) begin
            stray++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        tick(1);
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    task automatic drain(input string name);
        int cnt = 0;
        while (expQ.size() != 0 && cnt < 300) begin
            tick(1);
            cnt++;
        end
        check({name, "_drain"}, 32'(expQ.size()), 32'd0);
        tick(2);
    endtask

    task automatic waitTxValid(input string name);
        int cnt = 0;
        while (!txValid && cnt < 100) begin
            tick(1);
            cnt++;
        end
        check({name, "_txvalid"}, {31'd0, txValid}, 32'd1);
    endtask

    typedef struct {
        string           name;
        logic [0:8][7:0] frame;
        int              len;
        logic [0:3][7:0] rsp;
        int              nrsp;
        int              nWrites;
        int              nReadCycles;
        logic [31:0]     wAddr;
        logic [31:0]     wData;
        logic            expPause;
    } vec_t;

    vec_t vecs [12];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        vecs[0]  = '{"pause",         {8'h50, 64'h0},                              1, {8'h4B, 24'h0}, 1, 0, 0,   32'h0,  32'h0,        1'b1};
        vecs[1]  = '{"pause_again",   {8'h50, 64'h0},                              1, {8'h4B, 24'h0}, 1, 0, 0,   32'h0,  32'h0,        1'b1};
        vecs[2]  = '{"write_paused",  {8'h57, 32'h00000010, 32'hDEADBEEF},         9, {8'h4B, 24'h0}, 1, 1, 0,   32'h10, 32'hDEADBEEF, 1'b1};
        vecs[3]  = '{"read_paused",   {8'h52, 32'h00000010, 32'h0},                5, 32'hDEADBEEF,   4, 0, LAT, 32'h0,  32'h0,        1'b1};
        vecs[4]  = '{"write_other",   {8'h57, 32'h00000014, 32'h12345678},         9, {8'h4B, 24'h0}, 1, 1, 0,   32'h14, 32'h12345678, 1'b1};
        vecs[5]  = '{"read_other",    {8'h52, 32'h00000014, 32'h0},                5, 32'h12345678,   4, 0, LAT, 32'h0,  32'h0,        1'b1};
        vecs[6]  = '{"go",            {8'h47, 64'h0},                              1, {8'h4B, 24'h0}, 1, 0, 0,   32'h0,  32'h0,        1'b0};
        vecs[7]  = '{"go_again",      {8'h47, 64'h0},                              1, {8'h4B, 24'h0}, 1, 0, 0,   32'h0,  32'h0,        1'b0};
        vecs[8]  = '{"write_running", {8'h57, 32'h00000020, 32'hCAFEF00D},         9, {8'h45, 24'h0}, 1, 0, 0,   32'h0,  32'h0,        1'b0};
        vecs[9]  = '{"read_running",  {8'h52, 32'h00000010, 32'h0},                5, {8'h45, 24'h0}, 1, 0, 0,   32'h0,  32'h0,        1'b0};
        vecs[10] = '{"unknown",       {8'h13, 64'h0},                              1, {8'h3F, 24'h0}, 1, 0, 0,   32'h0,  32'h0,        1'b0};
        vecs[11] = '{"unknown_ff",    {8'hFF, 64'h0},                              1, {8'h3F, 24'h0}, 1, 0, 0,   32'h0,  32'h0,        1'b0};

        // Reset state
        tick(3);
        check("rst_pause", {31'd0, pause}, 32'd0);
        check("rst_ctrl", {31'd0, externalMemoryControl}, 32'd0);
        check("rst_modes", {26'd0, externalReadMode, externalWriteMode}, 32'd0);
        check("rst_tx", {23'd0, txValid, txData}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        tick(2);

        // Table-driven command frames
        for (int v = 0; v < 12; v++) begin
            int w0;
            int r0;
            w0 = writes;
            r0 = readCycles;
            for (int k = 0; k < vecs[v].nrsp; k++) expQ.push_back(vecs[v].rsp[k]);
            for (int k = 0; k < vecs[v].len; k++) sendByte(vecs[v].frame[k]);
            drain(vecs[v].name);
            check({vecs[v].name, "_pause"}, {31'd0, pause}, {31'd0, vecs[v].expPause});
            check({vecs[v].name, "_writes"}, 32'(writes - w0), 32'(vecs[v].nWrites));
            check({vecs[v].name, "_readcyc"}, 32'(readCycles - r0), 32'(vecs[v].nReadCycles));
            check({vecs[v].name, "_txidle"}, {31'd0, txValid}, 32'd0);
            if (vecs[v].nWrites != 0) begin
                check({vecs[v].name, "_waddr"}, lastWAddr, vecs[v].wAddr);
                check({vecs[v].name, "_wdata"}, lastWData, vecs[v].wData);
            end
        end
        check("overrun_quiet", {31'd0, overrun}, 32'd0);

        // Transmitter back-pressure mid-stream
        expQ.push_back(8'h4B);
        sendByte(8'h50);
        drain("stall_pause");
        expQ.push_back(8'hDE); expQ.push_back(8'hAD); expQ.push_back(8'hBE); expQ.push_back(8'hEF);
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
        begin
            int cnt = 0;
            while (expQ.size() > 3 && cnt < 100) begin
                tick(1);
                cnt++;
            end
        end
        txReady = 1'b0;
        check("stall_first_gone", 32'(expQ.size()), 32'd3);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check("stall_hold", {23'd0, txValid, txData}, {23'd0, 1'b1, 8'hAD});
        end
        txReady = 1'b1;
        drain("stall_rest");

        // Frame stalled below the timeout still completes
        expQ.push_back(8'h4B);
        sendByte(8'h47);
        drain("tmo_go");
        expQ.push_back(8'h45);
        sendByte(8'h52); sendByte(8'h00);
        tick(TMO - 10);
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
        drain("tmo_short");

        // Frame stalled past the timeout is dropped; pause unaffected
        expQ.push_back(8'h4B);
        sendByte(8'h50);
        drain("tmo_pause");
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h00);
        tick(TMO + 10);
        check("tmo_pause_kept", {31'd0, pause}, 32'd1);
        check("tmo_txidle", {31'd0, txValid}, 32'd0);
        expQ.push_back(8'h4B);
        sendByte(8'h47);
        drain("tmo_g");
        check("tmo_g_pause", {31'd0, pause}, 32'd0);

        // Byte arriving during a read reply is dropped and flagged
        expQ.push_back(8'h4B);
        sendByte(8'h50);
        drain("ovr_pause");
        txReady = 1'b0;
        expQ.push_back(8'hDE); expQ.push_back(8'hAD); expQ.push_back(8'hBE); expQ.push_back(8'hEF);
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h10);
        waitTxValid("ovr");
        check("ovr_before", {31'd0, overrun}, 32'd0);
        sendByte(8'h50);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        txReady = 1'b1;
        drain("ovr_read");
        expQ.push_back(8'h3F);
        sendByte(8'h13);
        drain("ovr_unknown");
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        check("ovr_pause", {31'd0, pause}, 32'd1);

        // Asynchronous reset mid-reply
        txReady = 1'b0;
        expQ.push_back(8'h4B);
        sendByte(8'h50);
        waitTxValid("mid_rst");
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_pause", {31'd0, pause}, 32'd0);
        check("mid_rst_tx", {31'd0, txValid}, 32'd0);
        check("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        check("mid_rst_ctrl", {31'd0, externalMemoryControl}, 32'd0);
        expQ.delete();
        txReady = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(2);
        expQ.push_back(8'h45);
        sendByte(8'h57); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h20);
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
        drain("post_rst_write");

        check("stray_port_activity", 32'(stray), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
